// File: rtl/pcie_phy_defs_pkg.sv
// Shared PHY definitions: comma symbol, default lock depth and the
// alignment FSM state encoding used by the serial front ends.
package pcie_phy_defs;

    // Comma / idle symbol, shared with the transmit-side serializer.
    localparam logic [7:0] COM_BYTE = 8'hBC;

    // Default number of back-to-back commas needed to declare lock.
    localparam int DEF_LOCK_COUNT = 4;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } align_state_t;

endpackage

// File: rtl/serial_paralelo_8.sv
// Serial-to-parallel receive front end: hunts for the comma symbol bit by
// bit, confirms byte alignment over LOCK_COUNT consecutive commas, then
// emits one aligned byte every 8 bit clocks.
//
// Ports:
//   clk_32f                in  bit-rate clock, rising edge
//   reset                  in  synchronous, active-high
//   data_in                in  serial lane, MSB first
//   data_serial_paralelo   out aligned byte, held between boundaries
//   valid_serial_paralelo  out payload flag (locked and byte != comma)
//   active                 out alignment locked, sticky until reset
//   byte_strobe            out one-cycle pulse when outputs update
module serial_paralelo_8
    import pcie_phy_defs::*;
#(
    parameter logic [7:0] COM_BYTE   = pcie_phy_defs::COM_BYTE,
    parameter int         LOCK_COUNT = DEF_LOCK_COUNT
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_serial_paralelo,
    output logic       valid_serial_paralelo,
    output logic       active,
    output logic       byte_strobe
);

    localparam int CNT_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] LOCK_VAL = CNT_W'(LOCK_COUNT);

    align_state_t     r_state;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_com_cnt;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_active;
    logic             r_strobe;

    logic [7:0]       w_nxt;
    logic             w_is_com;
    logic             w_byte_end;
    logic [CNT_W-1:0] w_com_inc;
    logic             w_com_sat;

    // Byte as it will look once the current bit is shifted in.
    assign w_nxt      = {r_shift[6:0], data_in};
    assign w_is_com   = (w_nxt == COM_BYTE);
    assign w_byte_end = (r_bit_cnt == 3'd7);
    assign w_com_inc  = r_com_cnt + CNT_W'(1);
    assign w_com_sat  = (r_com_cnt == LOCK_VAL);

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state   <= SEARCH;
            r_shift   <= 8'd0;
            r_bit_cnt <= 3'd0;
            r_com_cnt <= '0;
            r_data    <= 8'd0;
            r_valid   <= 1'b0;
            r_active  <= 1'b0;
            r_strobe  <= 1'b0;
        end else begin
            r_shift  <= w_nxt;
            r_strobe <= 1'b0;

            unique case (r_state)
                SEARCH: begin
                    // Bit-level hunt: any bit position may start a byte.
                    if (w_is_com) begin
                        r_bit_cnt <= 3'd0;
                        r_com_cnt <= CNT_W'(1);
                        if (LOCK_COUNT == 1) begin
                            r_state  <= ACTIVE;
                            r_active <= 1'b1;
                        end else begin
                            r_state <= LOCKING;
                        end
                    end
                end

                LOCKING: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_byte_end) begin
                        if (w_is_com) begin
                            if (!w_com_sat) begin
                                r_com_cnt <= w_com_inc;
                            end
                            if (w_com_inc == LOCK_VAL) begin
                                r_state  <= ACTIVE;
                                r_active <= 1'b1;
                            end
                        end else begin
                            // Broken comma run: resume the bit hunt.
                            r_state   <= SEARCH;
                            r_com_cnt <= '0;
                        end
                    end
                end

                ACTIVE: begin
                    // Locked: no realignment, bytes pass verbatim.
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_byte_end) begin
                        r_data   <= w_nxt;
                        r_valid  <= !w_is_com;
                        r_strobe <= 1'b1;
                    end
                end

                default: begin
                    r_state <= SEARCH;
                end
            endcase
        end
    end

    assign data_serial_paralelo  = r_data;
    assign valid_serial_paralelo = r_valid;
    assign active                = r_active;
    assign byte_strobe           = r_strobe;

endmodule

// File: tb/tb_serial_paralelo_8.sv
// Scoreboard bench for serial_paralelo_8: directed serial streams push
// expected bytes; a negedge monitor pops and checks on each strobe.
module tb_serial_paralelo_8;
    import pcie_phy_defs::*;

    logic       clk_32f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_serial_paralelo;
    logic       valid_serial_paralelo;
    logic       active;
    logic       byte_strobe;

    int checks;
    int failures;
    int cyc;

    logic [8:0] exp_q[$];
    logic [7:0] hold_d;
    logic       hold_v;
    int         last_strobe;

    serial_paralelo_8 dut (
        .clk_32f              (clk_32f),
        .reset                (reset),
        .data_in              (data_in),
        .data_serial_paralelo (data_serial_paralelo),
        .valid_serial_paralelo(valid_serial_paralelo),
        .active               (active),
        .byte_strobe          (byte_strobe)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    initial cyc = 0;
    always @(posedge clk_32f) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: pops on strobe, otherwise checks outputs hold.
    always @(negedge clk_32f) begin
        if (byte_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("sb_data", {24'd0, data_serial_paralelo}, {24'd0, e[7:0]});
                chk("sb_valid", {31'd0, valid_serial_paralelo}, {31'd0, e[8]});
                hold_d = e[7:0];
                hold_v = e[8];
            end
            if (last_strobe >= 0)
                chk("strobe_spacing", cyc - last_strobe, 32'd8);
            last_strobe = cyc;
        end else if (reset === 1'b0) begin
            chk("hold_data", {24'd0, data_serial_paralelo}, {24'd0, hold_d});
            chk("hold_valid", {31'd0, valid_serial_paralelo}, {31'd0, hold_v});
        end
        if (reset === 1'b1) begin
            hold_d      = 8'd0;
            hold_v      = 1'b0;
            last_strobe = -1;
        end
    end

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_payload(input logic [7:0] b);
        exp_q.push_back({(b != 8'hBC), b});
        send_byte(b);
    endtask

    task automatic idle_zeros(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        send_bit(1'($urandom));
        reset = 1'b0;
    endtask

    task automatic lock4();
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'hBC >> i));
        chk("active_before_lock", {31'd0, active}, 32'd0);
        send_bit(1'b0);
        chk("active_at_lock", {31'd0, active}, 32'd1);
    endtask

    initial begin
        repeat (20000) @(posedge clk_32f);
        failures = failures + 1;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        checks      = 0;
        failures    = 0;
        hold_d      = 8'd0;
        hold_v      = 1'b0;
        last_strobe = -1;
        reset       = 1'b1;
        data_in     = 1'b0;

        // 1. reset with random serial data
        for (int i = 0; i < 3; i++) begin
            send_bit(1'($urandom));
            chk("rst_outputs", {21'd0, active, byte_strobe,
                valid_serial_paralelo, data_serial_paralelo}, 32'd0);
            chk("rst_state", {30'd0, dut.r_state}, {30'd0, SEARCH});
        end
        reset = 1'b0;
        idle_zeros(16);
        chk("idle_active", {31'd0, active}, 32'd0);
        chk("idle_state", {30'd0, dut.r_state}, {30'd0, SEARCH});
        chk("idle_data", {24'd0, data_serial_paralelo}, 32'd0);

        // 2. offset 101, lock on 4 commas, then FF
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        lock4();
        chk("no_strobe_on_lock", {31'd0, byte_strobe}, 32'd0);
        send_payload(8'hFF);
        chk("ff_data", {24'd0, data_serial_paralelo}, 32'hFF);
        chk("ff_valid", {31'd0, valid_serial_paralelo}, 32'd1);
        chk("ff_strobe", {31'd0, byte_strobe}, 32'd1);
        send_bit(1'b0);
        chk("ff_strobe_drop", {31'd0, byte_strobe}, 32'd0);

        // 3. partial lock falls back, then a full lock
        pulse_reset();
        idle_zeros(8);
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'hBC);
        chk("partial_locking", {30'd0, dut.r_state}, {30'd0, LOCKING});
        send_byte(8'h55);
        chk("partial_search", {30'd0, dut.r_state}, {30'd0, SEARCH});
        chk("partial_active", {31'd0, active}, 32'd0);
        lock4();
        send_payload(8'h12);
        chk("p12_data", {24'd0, data_serial_paralelo}, 32'h12);

        // 4. comma filtering while active
        send_payload(8'h01);
        send_payload(8'hBC);
        chk("idle_bc_valid", {31'd0, valid_serial_paralelo}, 32'd0);
        send_payload(8'h02);

        // 6. embedded and shifted commas passed verbatim
        send_payload(8'h5E);
        send_payload(8'h2F);
        send_payload(8'hBC);
        send_payload(8'h5E);
        send_payload(8'hBC);
        send_payload(8'h00);
        chk("stress_active", {31'd0, active}, 32'd1);

        // 5. reset mid-byte while active
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        pulse_reset();
        chk("midrst_outputs", {21'd0, active, byte_strobe,
            valid_serial_paralelo, data_serial_paralelo}, 32'd0);
        chk("midrst_state", {30'd0, dut.r_state}, {30'd0, SEARCH});
        idle_zeros(8);
        lock4();
        send_payload(8'hA5);
        send_bit(1'b0);
        send_bit(1'b0);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
